// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register pending-write scoreboard.
// Serves decode reads with writeback bypass and raises the RAW/WAW stall.
module regfile_scoreboard #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            stall,
  input  logic            wvalid,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic            flush,
  output logic [NREG-1:0] busy_mask,
  output logic            sb_err
);

  typedef logic [XLEN-1:0]  word_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  word_t regs [NREG];
  cnt_t  cnt  [NREG];
  cnt_t  cnt_nxt [NREG];

  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] eff_nz;
  logic [NREG-1:0] busy_nxt;
  logic            fire;
  logic            err_set;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wb_hit[r] = wvalid && (wa == 5'(r)) && (r != 0);
      // One writeback retires exactly one pending write
      eff_nz[r] = (cnt[r] != '0) &&
                  !((cnt[r] == cnt_t'(1)) && wb_hit[r]);
    end
  end

  always_comb begin
    stall = 1'b0;
    if (ra1 != 5'd0 && eff_nz[ra1])
      stall = 1'b1;
    if (ra2 != 5'd0 && eff_nz[ra2])
      stall = 1'b1;
    if (issue_valid && issue_rd != 5'd0 &&
        cnt[issue_rd] == CNT_MAX)
      stall = 1'b1;
  end

  assign fire = issue_valid && !stall && !flush;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc;
      logic dec;
      inc = fire && (issue_rd == 5'(r)) && (r != 0);
      dec = wb_hit[r] && (cnt[r] != '0);
      cnt_nxt[r] = cnt[r];
      if (flush)
        cnt_nxt[r] = '0;
      else if (inc && !dec)
        cnt_nxt[r] = cnt[r] + cnt_t'(1);
      else if (dec && !inc)
        cnt_nxt[r] = cnt[r] - cnt_t'(1);
      busy_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  assign err_set = wvalid && (wa != 5'd0) &&
                   (cnt[wa] == '0) && !flush;

  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == 5'd0)
      rd1 = '0;
    else if (wvalid && wa == ra1)
      rd1 = wd;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == 5'd0)
      rd2 = '0;
    else if (wvalid && wa == ra2)
      rd2 = wd;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      busy_mask <= '0;
      sb_err    <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_nxt[r];
      if (wvalid && wa != 5'd0)
        regs[wa] <= wd;
      busy_mask <= busy_nxt;
      if (err_set)
        sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reads, bypass,
// RAW/WAW stall, saturation, flush, sb_err and async reset.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic [4:0]  ra1, ra2;
  logic [63:0] rd1, rd2;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        stall;
  logic        wvalid;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic        flush;
  logic [31:0] busy_mask;
  logic        sb_err;

  int n_chk = 0;
  int n_err = 0;

  regfile_scoreboard dut (
    .clk(clk), .resetn(resetn),
    .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .stall(stall),
    .wvalid(wvalid), .wa(wa), .wd(wd),
    .flush(flush),
    .busy_mask(busy_mask), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ra1 = 0; ra2 = 0;
    issue_valid = 0; issue_rd = 0;
    wvalid = 0; wa = 0; wd = 0;
    flush = 0;
  endtask

  initial begin
    resetn = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1;

    // reset state
    ra1 = 5;
    #1;
    chk("rst_rd1", rd1, 0);
    chk("rst_rd2", rd2, 0);
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_err", sb_err, 0);

    // claim x5, then write it back
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_valid = 0;
    chk("x5_busy", busy_mask, 32'h20);
    wvalid = 1; wa = 5; wd = 64'hDEAD_BEEF;
    #1;
    chk("x5_byp", rd1, 64'hDEAD_BEEF);
    chk("x5_nostall", stall, 0);
    tick();
    wvalid = 0;
    #1;
    chk("x5_rd", rd1, 64'hDEAD_BEEF);
    chk("x5_clear", busy_mask, 0);

    // x0 write dropped
    ra1 = 0; wvalid = 1; wa = 0; wd = 1;
    #1;
    chk("x0_byp", rd1, 0);
    tick();
    wvalid = 0;
    #1;
    chk("x0_rd", rd1, 0);
    chk("x0_err", sb_err, 0);

    // RAW on x7
    issue_valid = 1; issue_rd = 7;
    tick();
    issue_valid = 0;
    chk("raw_busy", busy_mask, 32'h80);
    ra1 = 7;
    #1;
    chk("raw_stall", stall, 1);
    wvalid = 1; wa = 7; wd = 64'h42;
    #1;
    chk("raw_wb_stall", stall, 0);
    chk("raw_wb_byp", rd1, 64'h42);
    tick();
    wvalid = 0;
    #1;
    chk("raw_done", busy_mask, 0);
    chk("raw_rd", rd1, 64'h42);

    // WAW and saturation on x3
    ra1 = 0;
    issue_valid = 1; issue_rd = 3;
    repeat (3) tick();
    chk("sat_stall", stall, 1);
    tick();
    issue_valid = 0;
    chk("sat_hold", busy_mask, 32'h8);
    wvalid = 1; wa = 3; wd = 1;
    tick();
    issue_valid = 1; issue_rd = 3;
    #1;
    chk("iwb_nostall", stall, 0);
    tick();
    issue_valid = 0;
    tick();
    wvalid = 0;
    chk("waw_one_left", busy_mask, 32'h8);
    ra2 = 3;
    #1;
    chk("waw_stall", stall, 1);
    wvalid = 1; wa = 3; wd = 3;
    #1;
    chk("waw_last_wb", stall, 0);
    tick();
    wvalid = 0; ra2 = 0;
    #1;
    chk("waw_done", busy_mask, 0);
    chk("waw_err", sb_err, 0);

    // flush with pending x4, x9
    issue_valid = 1; issue_rd = 4;
    tick();
    issue_rd = 9;
    tick();
    chk("fl_pend", busy_mask, 32'h210);
    issue_rd = 10; flush = 1;
    wvalid = 1; wa = 4; wd = 64'h11;
    tick();
    idle();
    ra1 = 4; ra2 = 10;
    #1;
    chk("fl_busy", busy_mask, 0);
    chk("fl_data", rd1, 64'h11);
    chk("fl_x10", stall, 0);
    chk("fl_err", sb_err, 0);

    // writeback to idle register
    ra1 = 12; ra2 = 0;
    wvalid = 1; wa = 12; wd = 64'h77;
    #1;
    chk("err_pre", sb_err, 0);
    tick();
    wvalid = 0;
    #1;
    chk("err_set", sb_err, 1);
    chk("err_data", rd1, 64'h77);
    chk("err_busy", busy_mask, 0);
    tick();
    chk("err_sticky", sb_err, 1);

    // async reset mid-cycle
    issue_valid = 1; issue_rd = 6;
    tick();
    issue_valid = 0;
    chk("ar_busy", busy_mask, 32'h40);
    #2 resetn = 0;
    #1;
    chk("ar_err", sb_err, 0);
    chk("ar_mask", busy_mask, 0);
    chk("ar_reg", rd1, 0);
    resetn = 1;
    ra1 = 6;
    #1;
    chk("ar_stall", stall, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Integer register file with a scoreboard for the in-order RV64 pipeline. It is the responder on the decode-stage read interface: decode drives ra1/ra2 and receives rd1/rd2. It also owns the writeback write port.
- Per-register pending counters track in-flight destination writes. From these it raises a decode stall so operands are never read stale.

Parameters:
- XLEN, 64, data width of word_t.
- NREG, 32, architectural register count; addresses are 5 bits wide.
- CNT_W, 2, pending counter width per register; maximum count is 3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ra1  in  5  read address 1 from decode; 0 when unused.
- ra2  in  5  read address 2 from decode; 0 when unused.
- rd1  out  XLEN  read data 1, combinational.
- rd2  out  XLEN  read data 2, combinational.
- issue_valid  in  1  the decode instruction is attempting to leave decode this cycle.
- issue_rd  in  5  destination register of the issuing instruction; 0 means no write.
- stall  out  1  combinational; decode must hold its instruction while this is high.
- wvalid  in  1  writeback write enable.
- wa  in  5  writeback address.
- wd  in  XLEN  writeback data.
- flush  in  1  pipeline kill; clears all pending counters.
- busy_mask  out  NREG  registered view; bit r = (cnt[r] != 0); bit 0 is always 0.
- sb_err  out  1  sticky, registered; set on writeback to a non-pending register.

Behaviour:
- Reset (resetn low, asynchronous):
  - regs[1..31] = 0.
  - cnt[all] = 0.
  - busy_mask = 0, sb_err = 0.
  - rd1/rd2 reflect the cleared array.
- x0 handling:
  - Reads of address 0 return 0.
  - Writes to wa = 0 are dropped.
  - issue_rd = 0 never changes a counter.
- Read path, with write-first bypass:
  - rdN = 0 if raN == 0.
  - Otherwise rdN = wd if wvalid && wa == raN.
  - Otherwise rdN = regs[raN].
- Write: if wvalid && wa != 0, then regs[wa] <= wd at the edge.
- Writeback effect per register r: wb_hit(r) = wvalid && wa == r && r != 0.
- Effective count: eff(r) = cnt[r] - wb_hit(r) when cnt[r] != 0; otherwise eff(r) = 0.
- stall is high if any of the following holds:
  - ra1 != 0 and eff(ra1) != 0;
  - ra2 != 0 and eff(ra2) != 0;
  - issue_valid and issue_rd != 0 and cnt[issue_rd] == 3 (counter full).
- Issue fire: fire = issue_valid && !stall && !flush.
- Counter update, per register r, at the edge:
  - Increment term inc = fire && issue_rd == r.
  - Decrement term dec = wb_hit(r) && cnt[r] != 0.
  - cnt[r] <= cnt[r] + inc - dec.
  - Simultaneous inc and dec leaves the count unchanged.
  - The counter never wraps. Overflow is prevented by stall; underflow is prevented by the dec guard.
- Flush:
  - All cnt[r] <= 0 at the next edge; this overrides inc and dec in that cycle.
  - A writeback in the flush cycle still writes its data.
  - After a flush, killed instructions never reach writeback.
- sb_err:
  - Set when wvalid && wa != 0 && cnt[wa] == 0 && !flush.
  - Cleared only by reset.
  - The data is still written and the counter stays 0.
- busy_mask: updated from the next-state counters every edge.
- stall has no dependency on flush. Decode applies flush priority itself.

Test Plan:
- Reset, then ra1 = 5, ra2 = 0 -> rd1 = 0, rd2 = 0, stall = 0, busy_mask = 0, sb_err = 0.
- Write x5 = 0xDEAD_BEEF, then read ra1 = 5 in the next cycle -> rd1 = 0xDEADBEEF.
  - Write x0 = 1 -> ra1 = 0 still reads 0.
- RAW hazard:
  - Issue with issue_rd = 7; busy_mask[7] = 1.
  - Next cycle ra1 = 7 with no writeback -> stall = 1.
  - Then wvalid, wa = 7, wd = 0x42 -> stall = 0 and rd1 = 0x42 in the same cycle (bypass); cnt[7] goes to 0.
- WAW and saturation:
  - Three issues to x3 -> cnt = 3.
  - A fourth issue_valid to x3 -> stall = 1 and the count stays 3.
  - Issue to x3 with a simultaneous wb to x3 -> count unchanged.
  - Three wbs -> busy_mask[3] = 0.
- Flush:
  - Pending x4 and x9; assert flush together with an issue to x10 and a wb to x4 (wd = 0x11).
  - Next cycle: busy_mask = 0, regs[4] = 0x11, x10 not pending.
- Error:
  - wb to x12 with cnt = 0 -> sb_err = 1 from the next cycle onward; regs[12] is written.
  - Assert resetn low mid-sequence -> sb_err and all counters clear immediately (asynchronous).
